// File: rtl/prog_downcounter.sv
// prog_downcounter: loadable, prescaled down-counter with one-shot,
// auto-reload and free-run modes, a single-cycle terminal-count pulse and a
// mode-dependent level output.
//
// Ports:
//   CLKEXT     in   1        sole clock, rising edge
//   RST_CTR_N  in   1        asynchronous active-low reset
//   EN         in   1        count enable (prescaler and counter)
//   LD         in   1        synchronous load strobe
//   CLR        in   1        synchronous abort (highest priority)
//   DB         in   WIDTH/2  upper half of load value
//   DD         in   WIDTH/2  lower half of load value
//   MODE       in   2        00 one-shot, 01 auto-reload, 10 free-run, 11 one-shot
//   PRESCALE   in   PW       one tick per PRESCALE+1 enabled RUN cycles
//   Q          out  WIDTH    current count
//   TC         out  1        terminal-count pulse
//   CTR_OUT    out  1        one-shot: set at terminal; periodic: toggles at terminal
//   BUSY       out  1        high while in RUN
//
// WIDTH must be even and at least 4.
module prog_downcounter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PW    = 8
) (
  input  logic               CLKEXT,
  input  logic               RST_CTR_N,
  input  logic               EN,
  input  logic               LD,
  input  logic               CLR,
  input  logic [WIDTH/2-1:0] DB,
  input  logic [WIDTH/2-1:0] DD,
  input  logic [1:0]         MODE,
  input  logic [PW-1:0]      PRESCALE,
  output logic [WIDTH-1:0]   Q,
  output logic               TC,
  output logic               CTR_OUT,
  output logic               BUSY
);

  localparam logic [1:0] MODE_RELOAD = 2'b01;
  localparam logic [1:0] MODE_FREE   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   reload_q, reload_d;
  logic [1:0]         mode_q, mode_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic               tc_q, tc_d;
  logic               ctr_q, ctr_d;
  logic               busy_q, busy_d;
  logic               tick;

  // State and output registers.
  always_ff @(posedge CLKEXT or negedge RST_CTR_N) begin
    if (!RST_CTR_N) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      reload_q <= '0;
      mode_q   <= 2'b00;
      presc_q  <= '0;
      pcnt_q   <= '0;
      tc_q     <= 1'b0;
      ctr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      tc_q     <= tc_d;
      ctr_q    <= ctr_d;
      busy_q   <= busy_d;
    end
  end

  // Next state: CLR beats LD beats tick processing; TC defaults low so it
  // only ever lasts one cycle.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    tc_d     = 1'b0;
    ctr_d    = ctr_q;
    tick     = 1'b0;

    if (CLR) begin
      state_d = ST_IDLE;
      q_d     = '0;
      pcnt_d  = '0;
      ctr_d   = 1'b0;
    end else if (LD) begin
      reload_d = {DB, DD};
      q_d      = {DB, DD};
      mode_d   = MODE;
      presc_d  = PRESCALE;
      pcnt_d   = '0;
      ctr_d    = 1'b0;
      state_d  = ST_RUN;
    end else if ((state_q == ST_RUN) && EN) begin
      if (pcnt_q == presc_q) begin
        tick   = 1'b1;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end

      if (tick) begin
        if (q_q != '0) begin
          q_d = q_q - WIDTH'(1);
        end else begin
          // Terminal event: reaching it from 0 makes a load of N last N+1 ticks.
          tc_d = 1'b1;
          case (mode_q)
            MODE_RELOAD: begin
              q_d   = reload_q;
              ctr_d = ~ctr_q;
            end
            MODE_FREE: begin
              q_d   = '1;
              ctr_d = ~ctr_q;
            end
            default: begin
              state_d = ST_DONE;
              ctr_d   = 1'b1;
            end
          endcase
        end
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  assign Q       = q_q;
  assign TC      = tc_q;
  assign CTR_OUT = ctr_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_prog_downcounter.sv
// Directed bench for prog_downcounter (WIDTH=16, PW=8). Each sample packs
// {Q, TC, CTR_OUT, BUSY} and compares against hand-computed values.
module tb_prog_downcounter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        ld;
  logic        clr;
  logic [7:0]  db;
  logic [7:0]  dd;
  logic [1:0]  mode;
  logic [7:0]  prescale;
  logic [15:0] q;
  logic        tc;
  logic        ctr_out;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  logic [18:0] obs;
  logic [18:0] expv;

  prog_downcounter #(.WIDTH(16), .PW(8)) dut (
    .CLKEXT   (clk),
    .RST_CTR_N(rst_n),
    .EN       (en),
    .LD       (ld),
    .CLR      (clr),
    .DB       (db),
    .DD       (dd),
    .MODE     (mode),
    .PRESCALE (prescale),
    .Q        (q),
    .TC       (tc),
    .CTR_OUT  (ctr_out),
    .BUSY     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] b, input logic [7:0] d,
                         input logic [1:0] m, input logic [7:0] p);
    db = b; dd = d; mode = m; prescale = p; ld = 1'b1;
    step();
    ld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; ld = 1'b0; clr = 1'b0;
    db = '0; dd = '0; mode = '0; prescale = '0;
    #3;
    obs = {q, tc, ctr_out, busy}; expv = {16'h0000, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, expv);
    end
    rst_n = 1'b1;
    en = 1'b1;
    step();
    step();
    obs = {q, tc, ctr_out, busy}; expv = {16'h0000, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL idle_after_reset: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_oneshot();
    logic [15:0] eq [6];
    logic        etc [6];
    logic        ectr[6];
    logic        ebsy[6];
    eq   = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0};
    etc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ectr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ebsy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    en = 1'b1;
    do_load(8'h00, 8'h03, 2'b00, 8'd0);
    // Input changes after the load must be ignored.
    mode = 2'b10; prescale = 8'd5;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      obs = {q, tc, ctr_out, busy}; expv = {eq[k], etc[k], ectr[k], ebsy[k]};
      vectors++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL oneshot_c%0d: got %h want %h", k, obs, expv);
      end
    end
  endtask

  task automatic test_done_hold();
    // Mode 11 behaves as one-shot; load 0 terminates on the first tick.
    en = 1'b1;
    do_load(8'h00, 8'h00, 2'b11, 8'd0);
    step();
    obs = {q, tc, ctr_out, busy}; expv = {16'h0000, 1'b1, 1'b1, 1'b0};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL mode3_load0_tc: got %h want %h", obs, expv);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      obs = {q, tc, ctr_out, busy}; expv = {16'h0000, 1'b0, 1'b1, 1'b0};
      vectors++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL done_hold_c%0d: got %h want %h", k, obs, expv);
      end
    end
  endtask

  task automatic test_autoreload();
    logic [15:0] qseq [6];
    logic [15:0] eq;
    qseq = '{16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0};
    en = 1'b1;
    do_load(8'h00, 8'h02, 2'b01, 8'd1);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) step();
      eq = qseq[k % 6];
      expv = {eq, (k > 0) && (k % 6 == 0), ((k / 6) % 2) == 1, 1'b1};
      obs = {q, tc, ctr_out, busy};
      vectors++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL autoreload_c%0d: got %h want %h", k, obs, expv);
      end
    end
  endtask

  task automatic test_freerun();
    int early;
    early = 0;
    en = 1'b1;
    do_load(8'h00, 8'h00, 2'b10, 8'd0);
    step();
    obs = {q, tc, ctr_out, busy}; expv = {16'hFFFF, 1'b1, 1'b1, 1'b1};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL freerun_first_tc: got %h want %h", obs, expv);
    end
    for (int k = 1; k <= 65536; k++) begin
      step();
      if (k < 65536 && tc) early++;
      if (k == 1) begin
        obs = {q, tc, ctr_out, busy}; expv = {16'hFFFE, 1'b0, 1'b1, 1'b1};
        vectors++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL freerun_wrap_dec: got %h want %h", obs, expv);
        end
      end
    end
    obs = {q, tc, ctr_out, busy}; expv = {16'hFFFF, 1'b1, 1'b0, 1'b1};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL freerun_second_tc: got %h want %h", obs, expv);
    end
    vectors++;
    if (early !== 0) begin
      errors++;
      $display("FAIL freerun_early_tc: got %0d early pulses want 0", early);
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b1;
    do_load(8'h00, 8'h11, 2'b00, 8'd1);
    step(); step(); step();
    // Prescaler is now one short of a tick with Q=0x0010.
    obs = {q, tc, ctr_out, busy}; expv = {16'h0010, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL en_pre_freeze: got %h want %h", obs, expv);
    end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      obs = {q, tc, ctr_out, busy}; expv = {16'h0010, 1'b0, 1'b0, 1'b1};
      vectors++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL en_frozen_c%0d: got %h want %h", k, obs, expv);
      end
    end
    en = 1'b1;
    step();
    obs = {q, tc, ctr_out, busy}; expv = {16'h000F, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL en_resume: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_collision();
    en = 1'b1;
    do_load(8'h00, 8'h40, 2'b00, 8'd0);
    db = 8'h00; dd = 8'h07; ld = 1'b1; clr = 1'b1;
    step();
    ld = 1'b0; clr = 1'b0;
    obs = {q, tc, ctr_out, busy}; expv = {16'h0000, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL clr_beats_ld: got %h want %h", obs, expv);
    end
    do_load(8'h00, 8'h01, 2'b01, 8'd0);
    step();
    // Q=0: the next enabled edge would be the terminal event.
    do_load(8'h00, 8'h05, 2'b01, 8'd0);
    obs = {q, tc, ctr_out, busy}; expv = {16'h0005, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL ld_beats_terminal: got %h want %h", obs, expv);
    end
    step();
    obs = {q, tc, ctr_out, busy}; expv = {16'h0004, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL ld_restart_dec: got %h want %h", obs, expv);
    end
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    obs = {q, tc, ctr_out, busy}; expv = {16'h0000, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL clr_no_en: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_async_reset();
    int stray;
    stray = 0;
    en = 1'b1;
    do_load(8'h12, 8'h34, 2'b10, 8'd0);
    obs = {q, tc, ctr_out, busy}; expv = {16'h1234, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL arst_loaded: got %h want %h", obs, expv);
    end
    #1 rst_n = 1'b0;
    #1;
    obs = {q, tc, ctr_out, busy}; expv = {16'h0000, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL arst_immediate: got %h want %h", obs, expv);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (tc || busy || q != 16'h0000) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL arst_no_activity: got %0d active cycles want 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    do_load(8'h00, 8'h01, 2'b00, 8'd0);
    step(); step();
    obs = {q, tc, ctr_out, busy}; expv = {16'h0000, 1'b1, 1'b1, 1'b0};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL b2b_first_tc: got %h want %h", obs, expv);
    end
    // Reload straight out of DONE clears CTR_OUT and restarts.
    do_load(8'h01, 8'h00, 2'b00, 8'd0);
    obs = {q, tc, ctr_out, busy}; expv = {16'h0100, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL b2b_reload: got %h want %h", obs, expv);
    end
    step();
    obs = {q, tc, ctr_out, busy}; expv = {16'h00FF, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL b2b_dec: got %h want %h", obs, expv);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_done_hold();
    test_autoreload();
    test_enable_hold();
    test_collision();
    test_async_reset();
    test_back_to_back();
    test_freerun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/prog_downcounter.md
PROG_DOWNCOUNTER -- requirements
Module: prog_downcounter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, as the counter width; it must be even and at least 4.
REQ-002 The block SHALL have parameter PW, default 8, as the prescaler width.
REQ-003 CLKEXT  in  1  sole clock; all state changes on the rising edge.
REQ-004 RST_CTR_N  in  1  asynchronous, active-low reset.
REQ-005 EN  in  1  count enable; gates both the prescaler and the counter.
REQ-006 LD  in  1  synchronous load strobe.
REQ-007 CLR  in  1  synchronous abort.
REQ-008 DB  in  WIDTH/2  upper half of the load value.
REQ-009 DD  in  WIDTH/2  lower half of the load value.
REQ-010 MODE  in  2  count mode: 00 one-shot, 01 auto-reload, 10 free-run, 11 treated as one-shot.
REQ-011 PRESCALE  in  PW  tick divider; one tick per PRESCALE+1 enabled RUN cycles.
REQ-012 Q  out  WIDTH  current count.
REQ-013 TC  out  1  single-cycle terminal-count pulse.
REQ-014 CTR_OUT  out  1  mode-dependent level output (see Function).
REQ-015 BUSY  out  1  high while in the RUN state.

Function
REQ-016 The state machine SHALL have three states, IDLE, RUN and DONE, and BUSY SHALL equal (state==RUN).
REQ-017 Per-cycle priority SHALL be: CLR, then LD, then tick processing.
REQ-018 CLR=1 SHALL move to IDLE and set Q=0, prescaler=0, TC=0 and CTR_OUT=0, regardless of EN or LD.
REQ-019 LD=1 with CLR=0, in any state and independent of EN, SHALL do all of the following at that edge:
- latch {DB,DD} into the reload register and into Q;
- latch MODE and PRESCALE;
- clear the prescaler, TC and CTR_OUT;
- enter RUN.
REQ-020 MODE and PRESCALE changes between loads SHALL have no effect.
REQ-021 Prescaler, in RUN with EN=1: if prescaler==latched PRESCALE, a tick SHALL occur and the prescaler SHALL clear to 0; otherwise the prescaler SHALL increment.
REQ-022 With EN=0, the prescaler, Q, state and CTR_OUT SHALL hold, and TC SHALL be 0.
REQ-023 On a tick with Q!=0, Q SHALL decrement by 1 with no other effect.
REQ-024 On a tick with Q==0, a terminal event SHALL occur: TC=1 for exactly that next cycle, then 0.
- One-shot: Q stays 0, state goes to DONE, CTR_OUT=1.
- Auto-reload: Q takes the reload value, state stays RUN, CTR_OUT toggles.
- Free-run: Q takes all-ones, state stays RUN, CTR_OUT toggles.
REQ-025 A load value N SHALL produce a terminal event on the (N+1)th tick after the load, so the period is (N+1)*(PRESCALE+1) enabled cycles.
REQ-026 A load value of 0 SHALL produce a terminal event on the first tick.
REQ-027 In IDLE and DONE, Q, the prescaler and CTR_OUT SHALL hold, and no ticks or TC SHALL occur.
REQ-028 A new LD SHALL be the only exit from DONE to RUN.
REQ-029 LD in the same cycle as a pending terminal event SHALL take priority: no TC, and the counter restarts from the new value.
REQ-030 Q arithmetic SHALL be modulo 2^WIDTH, and no other underflow path SHALL exist.
REQ-031 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-032 RST_CTR_N=0 SHALL immediately force state=IDLE, Q=0, reload=0, latched MODE=00, latched PRESCALE=0, prescaler=0, TC=0, CTR_OUT=0 and BUSY=0, independent of CLKEXT.
REQ-033 Reset deassertion SHALL take effect at the first CLKEXT edge with RST_CTR_N=1.
REQ-034 Reset mid-RUN SHALL discard the count, and no TC SHALL be generated.

Verification
REQ-035 Scenario: One-shot, WIDTH=16, DB=0x00, DD=0x03, PRESCALE=0, EN=1, pulse LD.
- Q SHALL read 3,2,1,0 on successive cycles.
- TC SHALL be high one cycle on the 4th tick.
- CTR_OUT SHALL then be 1, BUSY 0, and Q hold at 0.
REQ-036 Scenario: Auto-reload, load 0x0002, PRESCALE=1.
- TC SHALL pulse every 6 cycles.
- CTR_OUT SHALL toggle at each TC.
- Q SHALL cycle 2,1,0,2, each value held 2 cycles.
REQ-037 Scenario: Free-run, load 0x0000, PRESCALE=0.
- TC SHALL occur on the first tick, with Q then 0xFFFF.
- The next TC SHALL come 65536 ticks later.
REQ-038 Scenario: EN held low for 5 cycles mid-count at Q=0x0010.
- Q, prescaler and CTR_OUT SHALL be frozen and TC=0 throughout.
- Counting SHALL resume at 0x000F on the first tick after EN=1.
REQ-039 Scenario: Collision priorities.
- LD=1 and CLR=1 together: state SHALL be IDLE with Q=0.
- LD=1 on the terminal-event cycle with DB,DD=0x0005: no TC, Q SHALL be 5, state RUN.
REQ-040 Scenario: RST_CTR_N pulsed low between edges during RUN with Q=0x1234.
- Outputs SHALL reach their reset values before the next edge.
- No TC SHALL occur after release until the next LD.
